// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write ports, read ports, scoreboard set and init status.
// The debug read pair (dbg_idx_i / dbg_rdata_o) exists only when REGFILE_MP_DBG_EN is defined.
interface regfile_mp_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NREG   = 32,
  parameter int unsigned RPORTS = 2,
  parameter int unsigned WPORTS = 2
);
  localparam int unsigned IDXW = $clog2(NREG);

  logic [WPORTS-1:0]      rd_wen_i;
  logic [WPORTS*IDXW-1:0] rd_idx_i;
  logic [WPORTS*XLEN-1:0] rd_wdata_i;
  logic [RPORTS*IDXW-1:0] rs_idx_i;
  logic [RPORTS*XLEN-1:0] rs_rdata_o;
  logic [RPORTS-1:0]      rs_busy_o;
  logic                   sb_set_i;
  logic [IDXW-1:0]        sb_set_idx_i;
  logic                   init_busy_o;
`ifdef REGFILE_MP_DBG_EN
  logic [IDXW-1:0]        dbg_idx_i;
  logic [XLEN-1:0]        dbg_rdata_o;

  modport master (
    output rd_wen_i, rd_idx_i, rd_wdata_i, rs_idx_i, sb_set_i, sb_set_idx_i, dbg_idx_i,
    input  rs_rdata_o, rs_busy_o, init_busy_o, dbg_rdata_o
  );
  modport slave (
    input  rd_wen_i, rd_idx_i, rd_wdata_i, rs_idx_i, sb_set_i, sb_set_idx_i, dbg_idx_i,
    output rs_rdata_o, rs_busy_o, init_busy_o, dbg_rdata_o
  );
`else
  modport master (
    output rd_wen_i, rd_idx_i, rd_wdata_i, rs_idx_i, sb_set_i, sb_set_idx_i,
    input  rs_rdata_o, rs_busy_o, init_busy_o
  );
  modport slave (
    input  rd_wen_i, rd_idx_i, rd_wdata_i, rs_idx_i, sb_set_i, sb_set_idx_i,
    output rs_rdata_o, rs_busy_o, init_busy_o
  );
`endif
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, busy-bit scoreboard and post-reset zero fill.
// Optional raw-storage debug read port enabled by defining REGFILE_MP_DBG_EN.
module regfile_mp #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NREG   = 32,
  parameter int unsigned RPORTS = 2,
  parameter int unsigned WPORTS = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  regfile_mp_if.slave   bus
);
  localparam int unsigned IDXW  = $clog2(NREG);
  localparam int unsigned NSLOT = 2 ** IDXW;

  // Writable/readable indices: 1..NREG-1; index 0 and out-of-range slots are excluded.
  function automatic logic [NSLOT-1:0] live_mask();
    logic [NSLOT-1:0] m;
    m = '0;
    for (int unsigned i = 1; i < NSLOT; i++) m[i] = (i < NREG);
    return m;
  endfunction
  localparam logic [NSLOT-1:0] LIVE = live_mask();

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic            run;

  logic [IDXW-1:0]  widx [WPORTS];
  logic [XLEN-1:0]  wdat [WPORTS];
  logic [WPORTS-1:0] whit;
  logic [IDXW-1:0]  ridx [RPORTS];

  logic [XLEN-1:0]  regs_q [NREG];
  logic [NSLOT-1:0] busy_q, busy_d;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= IDXW'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + IDXW'(1);
      if (cnt_q == IDXW'(NREG - 1)) state_d = ST_RUN;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    run             = (state_q == ST_RUN);
    bus.init_busy_o = (state_q == ST_INIT);
  end

  // ---------------- port unpacking ----------------
  always_comb begin
    for (int unsigned k = 0; k < WPORTS; k++) begin
      widx[k] = bus.rd_idx_i[k*IDXW +: IDXW];
      wdat[k] = bus.rd_wdata_i[k*XLEN +: XLEN];
      whit[k] = run & bus.rd_wen_i[k] & LIVE[widx[k]];
    end
    for (int unsigned p = 0; p < RPORTS; p++) begin
      ridx[p] = bus.rs_idx_i[p*IDXW +: IDXW];
    end
  end

  // ---------------- storage (no reset; cleared by the INIT sweep) ----------------
  // Ports are visited in ascending order so the highest-numbered writer lands last.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!run) regs_q[cnt_q] <= '0;
      for (int unsigned k = 0; k < WPORTS; k++) begin
        if (whit[k]) regs_q[widx[k]] <= wdat[k];
      end
    end
  end

  // ---------------- scoreboard ----------------
  // Set is applied after the clears so a same-cycle reissue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      for (int unsigned k = 0; k < WPORTS; k++) begin
        if (whit[k]) busy_d[widx[k]] = 1'b0;
      end
      if (bus.sb_set_i && LIVE[bus.sb_set_idx_i]) busy_d[bus.sb_set_idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // ---------------- read ports with write bypass ----------------
  always_comb begin
    bus.rs_rdata_o = '0;
    bus.rs_busy_o  = '0;
    for (int unsigned p = 0; p < RPORTS; p++) begin
      if (run && LIVE[ridx[p]]) begin
        bus.rs_rdata_o[p*XLEN +: XLEN] = regs_q[ridx[p]];
        bus.rs_busy_o[p]               = busy_q[ridx[p]];
        for (int unsigned k = 0; k < WPORTS; k++) begin
          if (whit[k] && (widx[k] == ridx[p])) begin
            bus.rs_rdata_o[p*XLEN +: XLEN] = wdat[k];
            bus.rs_busy_o[p]               = 1'b0;
          end
        end
      end
    end
  end

`ifdef REGFILE_MP_DBG_EN
  // Raw storage view, valid in any state; no bypass.
  always_comb begin
    bus.dbg_rdata_o = '0;
    if (LIVE[bus.dbg_idx_i]) bus.dbg_rdata_o = regs_q[bus.dbg_idx_i];
  end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: the driver queues expected outputs per cycle, a monitor checks them.
module tb_regfile_mp;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned NREG   = 32;
  localparam int unsigned RPORTS = 2;
  localparam int unsigned WPORTS = 2;
  localparam int unsigned IDXW   = $clog2(NREG);

  localparam int unsigned K_RDATA = 0;
  localparam int unsigned K_BUSY  = 1;
  localparam int unsigned K_INIT  = 2;
  localparam int unsigned K_DBG   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .RPORTS(RPORTS), .WPORTS(WPORTS)) rf_if ();

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .RPORTS(RPORTS), .WPORTS(WPORTS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rf_if)
  );

  typedef struct {
    int unsigned     cyc;
    int unsigned     kind;
    int unsigned     port;
    logic [XLEN-1:0] val;
    string           name;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: at each falling edge, check every expectation queued for this cycle.
  initial begin : monitor
    exp_t            e;
    logic [XLEN-1:0] act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        case (e.kind)
          K_RDATA: act = rf_if.rs_rdata_o[e.port*XLEN +: XLEN];
          K_BUSY:  act = XLEN'(rf_if.rs_busy_o[e.port]);
          K_INIT:  act = XLEN'(rf_if.init_busy_o);
`ifdef REGFILE_MP_DBG_EN
          K_DBG:   act = rf_if.dbg_rdata_o;
`endif
          default: act = 'x;
        endcase
        checks++;
        if (e.cyc != cyc || act !== e.val) begin
          errors++;
          $display("FAIL %s port%0d cyc=%0d (queued %0d): got %h expected %h",
                   e.name, e.port, cyc, e.cyc, act, e.val);
        end
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input int unsigned kind, input int unsigned port,
                          input logic [XLEN-1:0] val, input string name);
    exp_t e;
    e = '{cyc, kind, port, val, name};
    sb_q.push_back(e);
  endtask

  task automatic exp_rd(input int unsigned port, input logic [XLEN-1:0] val,
                        input logic busy, input string name);
    expect_o(K_RDATA, port, val, {name, "_rdata"});
    expect_o(K_BUSY, port, XLEN'(busy), {name, "_busy"});
  endtask

  task automatic idle();
    rf_if.rd_wen_i     = '0;
    rf_if.rd_idx_i     = '0;
    rf_if.rd_wdata_i   = '0;
    rf_if.sb_set_i     = 1'b0;
    rf_if.sb_set_idx_i = '0;
  endtask

  task automatic wr(input int unsigned port, input int unsigned idx, input logic [XLEN-1:0] data);
    rf_if.rd_wen_i[port]                  = 1'b1;
    rf_if.rd_idx_i[port*IDXW +: IDXW]     = IDXW'(idx);
    rf_if.rd_wdata_i[port*XLEN +: XLEN]   = data;
  endtask

  task automatic rd(input int unsigned port, input int unsigned idx);
    rf_if.rs_idx_i[port*IDXW +: IDXW] = IDXW'(idx);
  endtask

  task automatic sbset(input int unsigned idx);
    rf_if.sb_set_i     = 1'b1;
    rf_if.sb_set_idx_i = IDXW'(idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    rf_if.rs_idx_i = '0;
`ifdef REGFILE_MP_DBG_EN
    rf_if.dbg_idx_i = '0;
`endif
    // Reset held for three edges.
    next_cyc();
    expect_o(K_INIT, 0, 64'd1, "init_in_reset");
    next_cyc();
    next_cyc();
    rst_n = 1'b1;

    // INIT: 31 busy cycles; writes and sb_set are ignored.
    for (int unsigned i = 0; i < NREG - 1; i++) begin
      idle();
      if (i == 28) wr(0, 5, 64'h55);
      if (i == 29) sbset(5);
      rd(0, 5);
      rd(1, 1);
      expect_o(K_INIT, 0, 64'd1, "init_busy");
      exp_rd(0, 64'd0, 1'b0, "init_read");
      next_cyc();
    end

    // RUN: every register reads 0 and not busy.
    for (int unsigned r = 0; r < NREG / 2; r++) begin
      idle();
      rd(0, 2 * r);
      rd(1, 2 * r + 1);
      expect_o(K_INIT, 0, 64'd0, "init_done");
      exp_rd(0, 64'd0, 1'b0, "post_init_even");
      exp_rd(1, 64'd0, 1'b0, "post_init_odd");
      next_cyc();
    end

    // Both ports write x5: port 1 wins, forwarded and stored.
    idle();
    wr(0, 5, 64'h1111);
    wr(1, 5, 64'h2222);
    rd(0, 5);
    rd(1, 5);
    exp_rd(0, 64'h2222, 1'b0, "dual_wr_fwd");
    exp_rd(1, 64'h2222, 1'b0, "dual_wr_fwd");
    next_cyc();
    idle();
    exp_rd(0, 64'h2222, 1'b0, "dual_wr_stored");
    exp_rd(1, 64'h2222, 1'b0, "dual_wr_stored");
    next_cyc();

    // Distinct indices on the two write ports.
    idle();
    wr(0, 9, 64'hA);
    wr(1, 10, 64'hB);
    rd(0, 9);
    rd(1, 10);
    exp_rd(0, 64'hA, 1'b0, "split_wr_fwd");
    exp_rd(1, 64'hB, 1'b0, "split_wr_fwd");
    next_cyc();
    idle();
    exp_rd(0, 64'hA, 1'b0, "split_wr_stored");
    exp_rd(1, 64'hB, 1'b0, "split_wr_stored");
    next_cyc();

    // x0 is hardwired: write and sb_set dropped.
    idle();
    wr(1, 0, 64'hDEAD);
    sbset(0);
    rd(0, 0);
    rd(1, 0);
    exp_rd(0, 64'd0, 1'b0, "x0_wr_cycle");
    exp_rd(1, 64'd0, 1'b0, "x0_wr_cycle");
    next_cyc();
    idle();
    exp_rd(0, 64'd0, 1'b0, "x0_after");
    next_cyc();

    // Scoreboard on x7.
    idle();
    sbset(7);
    rd(0, 7);
    rd(1, 7);
    exp_rd(0, 64'd0, 1'b0, "sb_set_cycle");
    next_cyc();
    idle();
    exp_rd(0, 64'd0, 1'b1, "sb_busy_n1");
    next_cyc();
    idle();
    exp_rd(1, 64'd0, 1'b1, "sb_busy_n2");
    next_cyc();
    idle();
    wr(0, 7, 64'h77);
    sbset(7);
    exp_rd(0, 64'h77, 1'b0, "sb_clear_bypass");
    exp_rd(1, 64'h77, 1'b0, "sb_clear_bypass");
    next_cyc();
    idle();
    exp_rd(0, 64'h77, 1'b1, "sb_set_wins");
    next_cyc();
    idle();
    wr(1, 7, 64'h78);
    exp_rd(0, 64'h78, 1'b0, "sb_clear_p1");
    next_cyc();
    idle();
    exp_rd(0, 64'h78, 1'b0, "sb_cleared");
    next_cyc();

    // Mid-RUN reset after x3=0xABC and x4 marked busy.
    idle();
    wr(0, 3, 64'hABC);
    sbset(4);
    rd(0, 3);
    rd(1, 4);
    exp_rd(0, 64'hABC, 1'b0, "pre_rst_fwd");
    exp_rd(1, 64'd0, 1'b0, "pre_rst_x4");
    next_cyc();
    idle();
    exp_rd(0, 64'hABC, 1'b0, "pre_rst_stored");
    exp_rd(1, 64'd0, 1'b1, "pre_rst_x4_busy");
    next_cyc();
    rst_n = 1'b0;
    idle();
    next_cyc();
    rst_n = 1'b1;
    for (int unsigned i = 0; i < NREG - 1; i++) begin
      expect_o(K_INIT, 0, 64'd1, "reinit_busy");
      exp_rd(1, 64'd0, 1'b0, "reinit_read");
      next_cyc();
    end
    expect_o(K_INIT, 0, 64'd0, "reinit_done");
    exp_rd(0, 64'd0, 1'b0, "reinit_x3");
    exp_rd(1, 64'd0, 1'b0, "reinit_x4");
    next_cyc();
    rd(0, 7);
    rd(1, 5);
    exp_rd(0, 64'd0, 1'b0, "reinit_x7");
    exp_rd(1, 64'd0, 1'b0, "reinit_x5");
    next_cyc();

`ifdef REGFILE_MP_DBG_EN
    // Debug port shows raw storage: old value during the write, new value after.
    idle();
    wr(0, 9, 64'h99);
    rf_if.dbg_idx_i = IDXW'(9);
    expect_o(K_DBG, 0, 64'd0, "dbg_old");
    next_cyc();
    idle();
    expect_o(K_DBG, 0, 64'h99, "dbg_new");
    next_cyc();
    rf_if.dbg_idx_i = '0;
    expect_o(K_DBG, 0, 64'd0, "dbg_x0");
    next_cyc();
`endif

    idle();
    next_cyc();
    next_cyc();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file, successor to the single-write/dual-read file in the pipe core.
- Configurable width, register count, read-port count and write-port count.
- Adds same-cycle write-to-read bypass across all write ports and a per-register scoreboard (busy bits) for issue-stage hazard detection.
- Adds a post-reset zero-fill sequencer, so the storage array needs no reset fan-out.
- Sits between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
- XLEN, 64, data width in bits.
- NREG, 32, number of architectural registers; register 0 is hardwired zero. Legal range 2 to 64.
- RPORTS, 2, number of read ports.
- WPORTS, 2, number of write ports.
- IDXW, $clog2(NREG), localparam; register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- rd_wen_i  in  WPORTS  per-port write enable.
- rd_idx_i  in  WPORTS*IDXW  per-port write index; port k occupies bits [k*IDXW +: IDXW].
- rd_wdata_i  in  WPORTS*XLEN  per-port write data.
- rs_idx_i  in  RPORTS*IDXW  per-port read index.
- rs_rdata_o  out  RPORTS*XLEN  per-port read data; combinational.
- rs_busy_o  out  RPORTS  per-port scoreboard busy flag; combinational.
- sb_set_i  in  1  mark a destination register pending (instruction issued).
- sb_set_idx_i  in  IDXW  register to mark pending.
- init_busy_o  out  1  high while the zero-fill sequencer runs; issue must stall.

Behaviour:
- Reset:
  - Any rising edge with rst_n=0 forces state INIT, sets fill counter cnt=1 and clears all busy bits.
  - Storage is not reset directly.
  - init_busy_o=1 from the first edge with rst_n=0 onward.
- INIT state:
  - Each edge with rst_n=1 writes 0 to reg[cnt] and increments cnt.
  - The edge that writes reg[NREG-1] moves the FSM to RUN. init_busy_o is therefore high for exactly NREG-1 cycles after reset release.
  - rd_wen_i and sb_set_i are ignored.
  - rs_rdata_o reads 0 and rs_busy_o reads 0.
- Reset mid-INIT or mid-RUN: return to INIT with cnt=1. No partial state is retained.
- RUN state writes:
  - On an edge where rd_wen_i[k]=1 and rd_idx_i[k]!=0, reg[rd_idx_i[k]] takes rd_wdata_i[k].
  - Writes to index 0 are dropped.
  - If two or more ports write the same index in one cycle, the highest-numbered port wins.
- RUN state reads (combinational, per port p):
  - rs_idx_i[p]==0 gives 0.
  - Otherwise, if any enabled write port targets the same index this cycle, the data from the highest-numbered such port is forwarded.
  - Otherwise the stored value is returned.
- Scoreboard:
  - One busy bit per register 1..NREG-1; busy[0] is constantly 0.
  - A write in RUN clears busy[idx] at the edge.
  - sb_set_i=1 with sb_set_idx_i!=0 sets busy[idx] at the edge.
  - If set and clear hit the same index in the same cycle, set wins (the younger producer).
  - rs_busy_o[p] = busy[rs_idx_i[p]] AND NOT (an enabled write targets rs_idx_i[p] this cycle). The clear is bypassed, so the consumer sees the value and not-busy in the same cycle.
- Index >= NREG (non-power-of-two NREG): writes dropped, reads return 0, rs_busy_o=0, sb_set ignored.
- No latency beyond combinational read; writes become visible in storage one cycle later but are forwarded in the write cycle.

Optional Feature:
- Macro: REGFILE_MP_DBG_EN.
- When defined, two extra ports are added:
  - dbg_idx_i  in  IDXW  debug read index.
  - dbg_rdata_o  out  XLEN  debug read data; combinational, raw storage value, no bypass, 0 for index 0.
- dbg_rdata_o is valid in both INIT and RUN; it is used by the testbench monitor and the trace dumper.
- When undefined, the ports do not exist and no extra read mux is built.

Test Plan:
- Reset held 3 cycles then released, NREG=32 → init_busy_o high for exactly 31 cycles after release. Afterwards all 32 reads return 0 and all rs_busy_o=0. Any write attempted during INIT is not visible.
- RUN: port0 writes x5=0x1111, port1 writes x5=0x2222 in the same cycle, read port 0 idx 5 → rs_rdata_o = 0x2222 in that cycle and in every later cycle.
- Write x0=0xDEAD on port 1 → reads of x0 return 0 in that cycle and later; busy[0] stays 0 even with sb_set_i on idx 0.
- sb_set x7 at cycle N → rs_busy_o=1 for idx 7 from N+1. Write x7=0x77 at cycle M → rs_busy_o=0 and rs_rdata_o=0x77 in cycle M itself. Simultaneous sb_set x7 with the write at M → busy=1 from M+1.
- Reset asserted for 1 cycle mid-RUN after writing x3=0xABC → busy bits cleared, init_busy_o high for 31 cycles, x3 reads 0 afterwards.
- With REGFILE_MP_DBG_EN: write x9=0x99 → dbg_rdata_o(idx 9) shows old value in the write cycle and 0x99 on the next.
